// File: rtl/fpu_pkg.sv
// Shared FPU definitions: exception flag positions, integer saturation limits
// and the float->int write-back result record.
package fpu_pkg;

  localparam int FLAG_NV = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Tag field width of the stored result; ftoi_wb's TAG_W must match it.
  localparam int FTOI_TAG_W = 5;

  typedef struct packed {
    logic [31:0]           y;
    logic [1:0]            flags;
    logic [FTOI_TAG_W-1:0] tag;
  } ftoi_res_t;

endpackage

// File: rtl/ftoi_classify.sv
// Combinational float->int result fix-up: saturates the converter output and
// derives {NV, NX} from the raw single-precision operand.
module ftoi_classify
  import fpu_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  output logic [31:0] y_o,
  output logic [1:0]  flags_o
);

  logic        sign;
  logic [7:0]  exp;
  logic [22:0] man;
  logic [7:0]  shift;
  logic [31:0] frac;
  logic [31:0] lost_mask;

  assign sign      = x_i[31];
  assign exp       = x_i[30:23];
  assign man       = x_i[22:0];
  // Bits of {1,m,8'b0} that truncation drops; only meaningful for 127 <= e <= 157.
  assign shift     = 8'd158 - exp;
  assign frac      = {1'b1, man, 8'b0};
  assign lost_mask = ~(32'hFFFF_FFFF << shift);

  always_comb begin
    // NOTE: outputs get a default before any branch so no path infers a latch.
    y_o     = y_i;
    flags_o = '0;
    if (exp == 8'hFF && man != '0) begin
      y_o              = INT_MAX;
      flags_o[FLAG_NV] = 1'b1;
    end else if (x_i == 32'hCF00_0000) begin
      y_o = INT_MIN;
    end else if (exp >= 8'd158) begin
      y_o              = sign ? INT_MIN : INT_MAX;
      flags_o[FLAG_NV] = 1'b1;
    end else if (exp <= 8'd126) begin
      y_o              = '0;
      flags_o[FLAG_NX] = |x_i[30:0];
    end else begin
      flags_o[FLAG_NX] = |(frac & lost_mask);
    end
  end

endmodule

// File: rtl/ftoi_wb.sv
// Float->int write-back stage: classifies converter results, queues them in a
// small FIFO and hands them to the register file over valid/ready.
module ftoi_wb
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = FTOI_TAG_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic [1:0]       out_flags,
  input  logic             flags_clr,
  output logic [1:0]       flags_sticky
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  ftoi_res_t        ram_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       sticky_q, sticky_d;

  logic [31:0] cls_y;
  logic [1:0]  cls_flags;
  ftoi_res_t   wr_res;
  ftoi_res_t   head;
  logic        push;
  logic        pop;

  ftoi_classify u_classify (
    .x_i    (in_x),
    .y_i    (in_y),
    .y_o    (cls_y),
    .flags_o(cls_flags)
  );

  assign wr_res = '{y: cls_y, flags: cls_flags, tag: FTOI_TAG_W'(in_tag)};
  assign head   = ram_q[rd_ptr_q];

  // Handshake status comes straight from the count register, so a full FIFO
  // refuses a push even while it is being popped.
  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Stale RAM contents never reach the outputs while the FIFO is empty.
  assign out_y        = out_valid ? head.y : '0;
  assign out_tag      = out_valid ? TAG_W'(head.tag) : '0;
  assign out_flags    = out_valid ? head.flags : '0;
  assign flags_sticky = sticky_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    sticky_d = sticky_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flags_clr)  sticky_d = '0;
    else if (pop)   sticky_d = sticky_q | head.flags;
  end

  // NOTE: the storage array has no reset; an entry is only observable once
  // count covers it, so clearing the pointers and count is sufficient.
  always_ff @(posedge clk) begin
    if (push) ram_q[wr_ptr_q] <= wr_res;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

endmodule

// File: tb/tb_ftoi_wb.sv
// Self-checking bench for ftoi_wb: real-arithmetic reference conversion plus a
// queue model of the FIFO, driven by directed and random stimulus.
`timescale 1ns/1ps
module tb_ftoi_wb;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam int HW    = 1 + 32 + TAG_W + 2;

  typedef struct {
    logic [31:0]      y;
    logic [1:0]       flags;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_x = '0;
  logic [31:0]      in_y = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_y;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       out_flags;
  logic             flags_clr = 1'b0;
  logic [1:0]       flags_sticky;

  exp_t             mq[$];
  logic [1:0]       m_sticky = 2'b00;
  logic [TAG_W-1:0] next_tag = '0;
  int               vectors = 0;
  int               miscompares = 0;

  ftoi_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_tag     (out_tag),
    .out_flags   (out_flags),
    .flags_clr   (flags_clr),
    .flags_sticky(flags_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic real to_real(logic [31:0] x);
    int  e = int'(x[30:23]);
    real mag;
    if (e == 0) mag = real'(x[22:0]) * (2.0 ** (-149));
    else        mag = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return x[31] ? -mag : mag;
  endfunction

  function automatic exp_t ref_conv(logic [31:0] x, logic [TAG_W-1:0] tag);
    exp_t r;
    real  v;
    int   yi;
    int   e = int'(x[30:23]);
    r.tag   = tag;
    r.flags = 2'b00;
    if (e == 255 && x[22:0] != 0) begin
      r.y = 32'h7FFF_FFFF; r.flags = 2'b10;
    end else begin
      if (e == 255) v = x[31] ? -1.0e40 : 1.0e40;
      else          v = to_real(x);
      if (v >= 2147483648.0) begin
        r.y = 32'h7FFF_FFFF; r.flags = 2'b10;
      end else if (v < -2147483648.0) begin
        r.y = 32'h8000_0000; r.flags = 2'b10;
      end else begin
        yi      = $rtoi(v);
        r.y     = yi;
        r.flags = (real'(yi) != v) ? 2'b01 : 2'b00;
      end
    end
    return r;
  endfunction

  // What the upstream converter would present; out-of-range cases are garbage.
  function automatic logic [31:0] conv_y(logic [31:0] x);
    real v;
    if (x[30:23] == 8'hFF) return $urandom;
    v = to_real(x);
    if (v >= 2147483648.0 || v < -2147483648.0) return $urandom;
    return $rtoi(v);
  endfunction

  function automatic logic [31:0] rand_x();
    logic [31:0] x = $urandom;
    case ($urandom_range(0, 9))
      0:       x[30:23] = 8'hFF;
      1:       x[30:23] = 8'h00;
      2:       x = 32'hCF00_0000;
      default: x[30:23] = 8'($urandom_range(118, 162));
    endcase
    return x;
  endfunction

  function automatic logic [HW-1:0] exp_head();
    if (mq.size() == 0) return '0;
    return {1'b1, mq[0].y, mq[0].tag, mq[0].flags};
  endfunction

  function automatic logic exp_ready();
    return mq.size() < DEPTH;
  endfunction

  task automatic set_input(input logic [31:0] x);
    in_x     = x;
    in_y     = conv_y(x);
    in_tag   = next_tag;
    next_tag = next_tag + 1'b1;
  endtask

  // One clock: the model decides transfers from its own occupancy, not the DUT.
  task automatic cycle(output bit pushed);
    bit popped;
    pushed = in_valid && (mq.size() < DEPTH);
    popped = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (flags_clr)   m_sticky = 2'b00;
    else if (popped) m_sticky = m_sticky | mq[0].flags;
    if (popped) void'(mq.pop_front());
    if (pushed) mq.push_back(ref_conv(in_x, in_tag));
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
    rstn      = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    mq.delete();
    m_sticky = 2'b00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vectors++;
    if ({out_valid, out_y, out_tag, out_flags} !== '0) begin
      miscompares++;
      $display("FAIL reset_head: got %h want 0", {out_valid, out_y, out_tag, out_flags});
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    vectors++;
    if (flags_sticky !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_sticky: got %b want 00", flags_sticky);
    end
  endtask

  task automatic test_directed();
    logic [31:0] xs [9] = '{32'h3FC0_0000, 32'h4F00_0000, 32'hCF00_0000, 32'h7FC0_0000,
                            32'hFF80_0000, 32'h0000_0001, 32'h4EFF_FFFF, 32'hBF80_0000,
                            32'h3F7F_FFFF};
    logic [31:0] ys [9] = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF,
                            32'h8000_0000, 32'h0000_0000, 32'h7FFF_FF80, 32'hFFFF_FFFF,
                            32'h0000_0000};
    logic [1:0]  fs [9] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01};
    logic [1:0]  sticky_exp = 2'b00;
    logic [TAG_W-1:0] tag;
    bit acc;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tag = next_tag;
      set_input(xs[i]);
      in_valid = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      vectors++;
      if ({out_valid, out_y, out_tag, out_flags} !== {1'b1, ys[i], tag, fs[i]}) begin
        miscompares++;
        $display("FAIL directed_out[%0d] x=%h: got v=%b y=%h tag=%0d f=%b want v=1 y=%h tag=%0d f=%b",
                 i, xs[i], out_valid, out_y, out_tag, out_flags, ys[i], tag, fs[i]);
      end
      out_ready = 1'b1;
      cycle(acc);
      out_ready  = 1'b0;
      sticky_exp = sticky_exp | fs[i];
      vectors++;
      if ({out_valid, flags_sticky} !== {1'b0, sticky_exp}) begin
        miscompares++;
        $display("FAIL directed_pop[%0d]: got v=%b sticky=%b want v=0 sticky=%b",
                 i, out_valid, flags_sticky, sticky_exp);
      end
    end
  endtask

  task automatic test_full();
    localparam int N = DEPTH + 2;
    logic [31:0] xs [N];
    int k = 0;
    int got = 0;
    bit acc, will_pop;
    do_reset();
    for (int i = 0; i < N; i++) xs[i] = rand_x();
    set_input(xs[0]);
    for (int cyc = 0; cyc < 60 && got < N; cyc++) begin
      in_valid  = (k < N);
      out_ready = (cyc >= DEPTH + 2);
      will_pop  = out_ready && (mq.size() > 0);
      cycle(acc);
      if (will_pop) got++;
      if (acc) begin
        k++;
        if (k < N) set_input(xs[k]);
      end
      vectors++;
      if (in_ready !== exp_ready()) begin
        miscompares++;
        $display("FAIL full_in_ready cyc=%0d: got %b want %b", cyc, in_ready, exp_ready());
      end
      vectors++;
      if ({out_valid, out_y, out_tag, out_flags} !== exp_head()) begin
        miscompares++;
        $display("FAIL full_head cyc=%0d: got %h want %h", cyc,
                 {out_valid, out_y, out_tag, out_flags}, exp_head());
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if (got != N) begin
      miscompares++;
      $display("FAIL full_drain_count: got %0d pops want %0d", got, N);
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_input(rand_x());
      in_valid = 1'b1;
      cycle(acc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      set_input(rand_x());
      cycle(acc);
      vectors++;
      if ({in_ready, out_valid} !== 2'b11) begin
        miscompares++;
        $display("FAIL b2b_status[%0d]: got ready=%b valid=%b want 1 1", i, in_ready, out_valid);
      end
      vectors++;
      if ({out_valid, out_y, out_tag, out_flags} !== exp_head()) begin
        miscompares++;
        $display("FAIL b2b_head[%0d]: got %h want %h", i,
                 {out_valid, out_y, out_tag, out_flags}, exp_head());
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8 && mq.size() > 0; i++) begin
      cycle(acc);
      vectors++;
      if ({out_valid, out_y, out_tag, out_flags} !== exp_head()) begin
        miscompares++;
        $display("FAIL b2b_drain[%0d]: got %h want %h", i,
                 {out_valid, out_y, out_tag, out_flags}, exp_head());
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit acc;
    do_reset();
    set_input(32'h3FC0_0000);
    in_valid = 1'b1;
    cycle(acc);
    for (int i = 0; i < 3; i++) begin
      set_input(rand_x());
      cycle(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle(acc);
    out_ready = 1'b0;
    vectors++;
    if (flags_sticky !== 2'b01) begin
      miscompares++;
      $display("FAIL midrst_pre_sticky: got %b want 01", flags_sticky);
    end
    #2 rstn = 1'b0;
    #1;
    vectors++;
    if ({out_valid, in_ready, flags_sticky} !== 4'b0100) begin
      miscompares++;
      $display("FAIL midrst_async: got valid=%b ready=%b sticky=%b want 0 1 00",
               out_valid, in_ready, flags_sticky);
    end
    mq.delete();
    m_sticky = 2'b00;
    @(negedge clk);
    rstn = 1'b1;
    set_input(32'h3FC0_0000);
    in_valid = 1'b1;
    cycle(acc);
    set_input(32'h7FC0_0000);
    cycle(acc);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle(acc);
    vectors++;
    if (flags_sticky !== 2'b01) begin
      miscompares++;
      $display("FAIL clr_pre_sticky: got %b want 01", flags_sticky);
    end
    flags_clr = 1'b1;
    cycle(acc);
    flags_clr = 1'b0;
    out_ready = 1'b0;
    vectors++;
    if ({out_valid, flags_sticky} !== 3'b000) begin
      miscompares++;
      $display("FAIL clr_pop_priority: got valid=%b sticky=%b want 0 00", out_valid, flags_sticky);
    end
  endtask

  task automatic test_random();
    bit acc = 1'b1;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        set_input(rand_x());
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flags_clr = ($urandom_range(0, 15) == 0);
      cycle(acc);
      vectors++;
      if ({in_ready, flags_sticky} !== {exp_ready(), m_sticky}) begin
        miscompares++;
        $display("FAIL rand_status[%0d]: got ready=%b sticky=%b want ready=%b sticky=%b",
                 i, in_ready, flags_sticky, exp_ready(), m_sticky);
      end
      vectors++;
      if ({out_valid, out_y, out_tag, out_flags} !== exp_head()) begin
        miscompares++;
        $display("FAIL rand_head[%0d]: got %h want %h", i,
                 {out_valid, out_y, out_tag, out_flags}, exp_head());
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flags_clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
